// File: rtl/prio_irq_ctrl.sv
// Registered priority encoder with rising-edge event capture, eligibility mask,
// fixed-priority or round-robin selection and a valid/ack handshake.
module prio_irq_ctrl #(
  parameter int N = 8,
  parameter int MODE = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] code,
  output logic         idle
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state_r, state_s;
  logic [N-1:0] req_q_r;
  logic [N-1:0] pending_r, pending_s;
  logic [W-1:0] code_r, code_s;
  logic [W-1:0] ptr_r, ptr_s;
  logic         valid_r, valid_s;
  logic [N-1:0] set_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] elig_s;
  logic         xfer_s;

  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] e);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin
        w = W'(i);
      end
    end
    return w;
  endfunction

  // Search upward from start, wrapping at N rather than at 2^W.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] e, input logic [W-1:0] start);
    logic [W-1:0] w;
    logic         hit;
    int           idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!hit && e[idx]) begin
        w   = W'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  // Event capture, grant selection and handshake next-state logic.
  always_comb begin
    set_s     = req & ~req_q_r;
    elig_s    = pending_r & mask;
    xfer_s    = (state_r == BUSY) && ack;
    clr_s     = '0;
    state_s   = state_r;
    valid_s   = valid_r;
    code_s    = code_r;
    ptr_s     = ptr_r;
    for (int i = 0; i < N; i++) begin
      clr_s[i] = xfer_s && (code_r == W'(i));
    end
    case (state_r)
      IDLE: begin
        if (elig_s != '0) begin
          state_s = BUSY;
          valid_s = 1'b1;
          code_s  = (MODE == 1) ? pick_rr(elig_s, ptr_r) : pick_fixed(elig_s);
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (ack) begin
          state_s = IDLE;
          valid_s = 1'b0;
          if (MODE == 1) begin
            ptr_s = (code_r == W'(N - 1)) ? {W{1'b0}} : code_r + {{(W-1){1'b0}}, 1'b1};
          end else begin
            ptr_s = '0;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
    // A fresh edge on the channel being acknowledged outranks the clear.
    pending_s = (pending_r & ~clr_s) | set_s;
  end

  // State registers; reset drops pending events and any outstanding grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_r   <= '0;
      pending_r <= '0;
      state_r   <= IDLE;
      code_r    <= '0;
      ptr_r     <= '0;
      valid_r   <= 1'b0;
    end else begin
      req_q_r   <= req;
      pending_r <= pending_s;
      state_r   <= state_s;
      code_r    <= code_s;
      ptr_r     <= ptr_s;
      valid_r   <= valid_s;
    end
  end

  assign valid = valid_r;
  assign code  = code_r;
  assign idle  = (state_r == IDLE) && (pending_r == '0);

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Directed bench: fixed-priority instance (N=8) driven from a vector table,
// round-robin instance (N=5) and reset corner cases as hand-written sequences.
module tb_prio_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req0, mask0;
  logic       ack0, valid0, idle0;
  logic [2:0] code0;
  logic [4:0] req1, mask1;
  logic       ack1, valid1, idle1;
  logic [2:0] code1;

  int checks;
  int failures;

  prio_irq_ctrl #(.N(8), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .mask(mask0), .ack(ack0),
    .valid(valid0), .code(code0), .idle(idle0)
  );

  prio_irq_ctrl #(.N(5), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .mask(mask1), .ack(ack1),
    .valid(valid1), .code(code1), .idle(idle1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       ev;
    logic [2:0] ec;
    logic       ei;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int exp_rr[6];
    checks   = 0;
    failures = 0;

    // fixed priority: 5,3,1; mask hold on 6; collision on 0; ack while idle
    tbl[0]  = '{8'h2A, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 1'b0};
    tbl[2]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 1'b0};
    tbl[3]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd3, 1'b0};
    tbl[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[5]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[6]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[7]  = '{8'h40, 8'hBF, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[8]  = '{8'h40, 8'hBF, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[9]  = '{8'h40, 8'hFF, 1'b0, 1'b1, 3'd6, 1'b0};
    tbl[10] = '{8'hC0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0};
    tbl[11] = '{8'h40, 8'hFF, 1'b0, 1'b1, 3'd6, 1'b0};
    tbl[12] = '{8'h40, 8'hFF, 1'b1, 1'b0, 3'd6, 1'b0};
    tbl[13] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd7, 1'b0};
    tbl[14] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd7, 1'b1};
    tbl[15] = '{8'h01, 8'hFF, 1'b0, 1'b0, 3'd7, 1'b0};
    tbl[16] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[17] = '{8'h01, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[18] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[19] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[20] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[21] = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[22] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1};

    exp_rr = '{0, 1, 2, 3, 4, 0};

    rst_n = 1'b0;
    req0  = 8'h00; mask0 = 8'hFF; ack0 = 1'b0;
    req1  = 5'h00; mask1 = 5'h1F; ack1 = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_valid0", int'(valid0), 0);
      chk("reset_code0", int'(code0), 0);
      chk("reset_idle0", int'(idle0), 1);
      chk("reset_valid1", int'(valid1), 0);
      chk("reset_idle1", int'(idle1), 1);
    end

    for (int i = 0; i < 23; i++) begin
      req0  = tbl[i].req;
      mask0 = tbl[i].mask;
      ack0  = tbl[i].ack;
      step();
      chk($sformatf("vec%0d_valid", i), int'(valid0), int'(tbl[i].ev));
      chk($sformatf("vec%0d_code", i), int'(code0), int'(tbl[i].ec));
      chk($sformatf("vec%0d_idle", i), int'(idle0), int'(tbl[i].ei));
    end
    req0 = 8'h00; ack0 = 1'b0;

    // round-robin with ack held high; channel 0 re-pulsed on its own ack edge
    req1 = 5'h1F;
    ack1 = 1'b1;
    step();
    req1 = 5'h00;
    for (int g = 0; g < 6; g++) begin
      cyc = 0;
      do begin
        step();
        req1 = 5'h00;
        cyc++;
      end while (!valid1 && cyc < 6);
      chk($sformatf("rr%0d_valid", g), int'(valid1), 1);
      chk($sformatf("rr%0d_code", g), int'(code1), exp_rr[g]);
      chk($sformatf("rr%0d_spacing", g), cyc, (g == 0) ? 1 : 2);
      if (g == 0) begin
        req1 = 5'h01;
      end
    end
    step();
    chk("rr_end_valid", int'(valid1), 0);
    chk("rr_end_idle", int'(idle1), 1);
    ack1 = 1'b0;

    // asynchronous reset in the middle of a grant
    req0 = 8'h10;
    step();
    req0 = 8'h00;
    step();
    chk("pre_rst_valid", int'(valid0), 1);
    chk("pre_rst_code", int'(code0), 4);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid0), 0);
    chk("async_rst_idle", int'(idle0), 1);
    chk("async_rst_code", int'(code0), 0);

    // request already high when reset is released counts as one event
    step();
    req0 = 8'h04;
    #3 rst_n = 1'b1;
    step();
    chk("hot_req_valid", int'(valid0), 0);
    chk("hot_req_idle", int'(idle0), 0);
    step();
    chk("hot_req_grant_valid", int'(valid0), 1);
    chk("hot_req_grant_code", int'(code0), 2);
    ack0 = 1'b1;
    step();
    chk("hot_req_ack_valid", int'(valid0), 0);
    chk("hot_req_ack_idle", int'(idle0), 1);
    ack0 = 1'b0;
    step();
    chk("held_req_no_event", int'(valid0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_irq_ctrl.md
# prio_irq_ctrl

Parametrised, registered priority encoder with event capture, masking and a valid/ack handshake, generalising the 8-to-3 combinational priority encoder. Rising edges on N request lines are latched as pending events, qualified by a mask, and one winner is presented as a binary code held stable until acknowledged. Selection is either fixed priority (highest index wins) or round-robin. The block sits between peripheral event lines and a single sequential consumer (controller FSM or CPU interrupt port).

## Interface
- N, 8: number of request channels; legal range 2..256, non-power-of-two allowed.
- W, $clog2(N): code width; derived, never overridden.
- MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  level request lines, synchronous to clk; a 0->1 transition is one event.
- mask  input  N  1 = channel eligible for selection; does not gate capture.
- ack  input  1  consumer accepts the presented code.
- valid  output  1  code holds a granted channel.
- code  output  W  index of the granted channel.
- idle  output  1  no pending events and no grant outstanding; equivalent to the reference block's Idle.

## Operation
- Registers: req_q[N], pending[N], state {IDLE, BUSY}, code[W], ptr[W] (round-robin start index, MODE=1 only).
- Capture: each edge, req_q <= req. pending[i] is set when req[i]=1 and req_q[i]=0. Capture happens regardless of mask or state.
- Eligible vector: E = pending & mask.
- IDLE: if E != 0, go to BUSY at the next edge, with valid <= 1 and code <= winner(E). Otherwise stay in IDLE.
- winner, MODE=0: highest set index of E.
- winner, MODE=1: first set index of E searching upward from ptr and wrapping from N-1 to 0. Wrap is at N, not 2^W.
- BUSY: code and valid hold regardless of req, mask or pending changes.
- Leaving BUSY: on an edge with ack=1, clear pending[code], set valid <= 0 and return to IDLE.
- ptr update (MODE=1): on that same edge, ptr <= (code == N-1) ? 0 : code+1.
- Ack gating: ack while not valid is ignored.
- Capture/clear collision: if a new edge on channel code is captured on the ack edge, set wins and pending[code] stays 1.
- Masked channel: a masked channel keeps its pending bit indefinitely and becomes eligible when unmasked.
- idle = (state == IDLE) && (pending == 0). This is combinational from registers, so it is glitch-free relative to clk.
- Reset values: req_q=0, pending=0, state=IDLE, code=0, ptr=0, valid=0, idle=1.
  - Because req_q resets to 0, a request already high at reset release registers as one event.
  - Reset mid-grant drops all pending events and the outstanding grant immediately, without waiting for a clock.

## Timing
- Edge-to-valid latency:
  - req[i] rises before edge t, so pending[i]=1 after t.
  - If IDLE and eligible, valid=1 and code=i after edge t+1.
  - Minimum latency is 2 cycles.
- Handshake: the transfer occurs on an edge where valid=1 and ack=1.
- After a transfer, valid is 0 for at least one cycle. Next grant is at the earliest one edge after the ack edge, so the maximum throughput is one grant per 2 cycles, with ack held high continuously.
- ack may be held high permanently.
- Each grant consumes exactly one pending event. Repeated edges on a channel that is already pending merge into one event; there is no counting.

## Test plan
- Reset and idle: rst_n=0, then release with req=0 -> valid=0, code=0, idle=1 for 10 cycles. Assert rst_n=0 asynchronously mid-BUSY -> valid=0 and idle=1 before the next clk edge.
- Fixed priority, N=8, MODE=0, mask=FF:
  - req edges on 3, 5 and 1 in the same cycle -> grants 5, 3, 1 in order, each 2 cycles apart with ack held.
  - idle=1 after the third ack.
- Round-robin, N=5, MODE=1, all pending:
  - Grants are 0,1,2,3,4,0 (with re-pulses).
  - After granting 4, ptr wraps to 0 (not 5..7); code never exceeds 4.
- Mask and hold:
  - Edge on channel 6 with mask[6]=0 -> no valid, idle=0.
  - Set mask[6]=1 -> valid with code=6 one edge later.
  - While BUSY, toggle mask and pulse channel 7 -> code stays 6 until ack.
- Collision and ignore:
  - Re-pulse the granted channel so its edge lands on the ack edge -> pending stays set and the same code is regranted 1 cycle after valid drops.
  - ack pulses while valid=0 -> no state change.
